// File: rtl/grid_solver_core_if.sv
// Host-side bus of the grid solver: given loading, start, readback and status.
interface grid_solver_core_if #(
   parameter int unsigned ORDER = 2
);
   localparam int unsigned L     = ORDER * ORDER;
   localparam int unsigned CELLS = L * L;
   localparam int unsigned VW    = $clog2(L + 1);
   localparam int unsigned AW    = $clog2(CELLS);
   localparam int unsigned CW    = 32;

   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [VW-1:0] wr_value;
   logic          start;
   logic [AW-1:0] rd_addr;
   logic [VW-1:0] rd_value;
   logic          busy;
   logic          done;
   logic          success;
   logic          timeout;
   logic [CW-1:0] cycle_count;

   modport master (
      output wr_en, wr_addr, wr_value, start, rd_addr,
      input  rd_value, busy, done, success, timeout, cycle_count
   );

   modport slave (
      input  wr_en, wr_addr, wr_value, start, rd_addr,
      output rd_value, busy, done, success, timeout, cycle_count
   );
endinterface

// File: rtl/grid_solver_core.sv
// Backtracking Sudoku solver: mask-building INIT pass over the givens, then a
// one-cell-per-cycle depth-first search with a cycle budget.
module grid_solver_core #(
   parameter int unsigned ORDER      = 2,
   parameter int unsigned MAX_CYCLES = 20000
) (
   input logic               clock,
   input logic               reset,
   grid_solver_core_if.slave bus
);
   localparam int unsigned L     = ORDER * ORDER;
   localparam int unsigned CELLS = L * L;
   localparam int unsigned VW    = $clog2(L + 1);
   localparam int unsigned AW    = $clog2(CELLS);
   localparam int unsigned CW    = 32;
   localparam int unsigned RW    = $clog2(L);
   localparam int unsigned IW    = $clog2(CELLS + 1) + 1;

   typedef enum logic [1:0] {S_IDLE, S_INIT, S_SOLVE, S_DONE} state_t;

   state_t        r_state;
   logic [VW-1:0] r_val [CELLS];
   logic [CELLS-1:0] r_given;
   logic [L-1:0]  r_row [L];
   logic [L-1:0]  r_col [L];
   logic [L-1:0]  r_blk [L];
   logic [IW-1:0] r_idx;
   logic          r_fwd;
   logic          r_conflict;
   logic          r_busy;
   logic          r_done;
   logic          r_success;
   logic          r_timeout;
   logic [CW-1:0] r_count;

   logic [AW-1:0] w_cell;
   logic [RW-1:0] w_row, w_col, w_blk;
   logic [VW-1:0] w_cur, w_cand;
   logic [L-1:0]  w_used, w_above, w_avail, w_cur_bit, w_new_bit;
   logic          w_given, w_found, w_wr_ok;
   logic [IW-1:0] w_idx_inc, w_idx_dec;

   function automatic logic [L-1:0] f_bit(input logic [VW-1:0] v);
      f_bit = (v == '0) ? '0 : (L'(1) << (v - VW'(1)));
   endfunction

   // Current-cell coordinates and the union of its three occupancy masks
   assign w_cell    = r_idx[AW-1:0];
   assign w_row     = RW'(w_cell / AW'(L));
   assign w_col     = RW'(w_cell % AW'(L));
   assign w_blk     = (w_row / RW'(ORDER)) * RW'(ORDER) + w_col / RW'(ORDER);
   assign w_cur     = r_val[w_cell];
   assign w_given   = r_given[w_cell];
   assign w_used    = r_row[w_row] | r_col[w_col] | r_blk[w_blk];
   assign w_cur_bit = f_bit(w_cur);
   assign w_idx_inc = r_idx + IW'(1);
   assign w_idx_dec = r_idx - IW'(1);

   // Bits for values strictly above the current one (shift past L wraps to all-zero)
   assign w_above   = ~((L'(1) << w_cur) - L'(1));
   assign w_avail   = ~w_used & w_above;
   assign w_found   = |w_avail;
   assign w_new_bit = w_found ? f_bit(w_cand) : '0;

   always_comb begin
      w_cand = '0;
      for (int i = L - 1; i >= 0; i--) begin
         if (w_avail[i]) w_cand = VW'(i + 1);
      end
   end

   assign w_wr_ok = bus.wr_en && (bus.wr_value <= VW'(L)) && (32'(bus.wr_addr) < CELLS);

   assign bus.rd_value    = (32'(bus.rd_addr) < CELLS) ? r_val[bus.rd_addr] : '0;
   assign bus.busy        = r_busy;
   assign bus.done        = r_done;
   assign bus.success     = r_success;
   assign bus.timeout     = r_timeout;
   assign bus.cycle_count = r_count;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state    <= S_IDLE;
         for (int i = 0; i < CELLS; i++) r_val[i] <= '0;
         r_given    <= '0;
         for (int i = 0; i < L; i++) begin
            r_row[i] <= '0;
            r_col[i] <= '0;
            r_blk[i] <= '0;
         end
         r_idx      <= '0;
         r_fwd      <= 1'b1;
         r_conflict <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_success  <= 1'b0;
         r_timeout  <= 1'b0;
         r_count    <= '0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (w_wr_ok) begin
                  r_val[bus.wr_addr]   <= bus.wr_value;
                  r_given[bus.wr_addr] <= (bus.wr_value != '0);
               end
               if (bus.start) begin
                  r_state    <= S_INIT;
                  r_idx      <= '0;
                  for (int i = 0; i < L; i++) begin
                     r_row[i] <= '0;
                     r_col[i] <= '0;
                     r_blk[i] <= '0;
                  end
                  r_conflict <= 1'b0;
                  r_busy     <= 1'b1;
                  r_done     <= 1'b0;
                  r_success  <= 1'b0;
                  r_timeout  <= 1'b0;
                  r_count    <= '0;
               end
            end
            S_INIT: begin
               if (!w_given) begin
                  r_val[w_cell] <= '0;
               end else if ((w_used & w_cur_bit) != '0) begin
                  r_conflict <= 1'b1;
               end else begin
                  r_row[w_row] <= r_row[w_row] | w_cur_bit;
                  r_col[w_col] <= r_col[w_col] | w_cur_bit;
                  r_blk[w_blk] <= r_blk[w_blk] | w_cur_bit;
               end
               if (r_idx == IW'(CELLS - 1)) begin
                  r_state <= S_SOLVE;
                  r_idx   <= '0;
                  r_fwd   <= 1'b1;
               end else begin
                  r_idx <= w_idx_inc;
               end
            end
            S_SOLVE: begin
               // Terminal conditions are resolved in the cycle after the last step
               if (r_conflict || (r_idx == IW'(CELLS)) || (r_idx == '1)) begin
                  r_state   <= S_DONE;
                  r_busy    <= 1'b0;
                  r_done    <= 1'b1;
                  r_success <= !r_conflict && (r_idx == IW'(CELLS));
               end else if ((MAX_CYCLES != 0) && (r_count == CW'(MAX_CYCLES))) begin
                  r_state   <= S_DONE;
                  r_busy    <= 1'b0;
                  r_done    <= 1'b1;
                  r_timeout <= 1'b1;
               end else begin
                  r_count <= r_count + CW'(1);
                  if (w_given) begin
                     r_idx <= r_fwd ? w_idx_inc : w_idx_dec;
                  end else begin
                     r_row[w_row]  <= (r_row[w_row] & ~w_cur_bit) | w_new_bit;
                     r_col[w_col]  <= (r_col[w_col] & ~w_cur_bit) | w_new_bit;
                     r_blk[w_blk]  <= (r_blk[w_blk] & ~w_cur_bit) | w_new_bit;
                     r_val[w_cell] <= w_found ? w_cand : '0;
                     r_fwd         <= w_found;
                     r_idx         <= w_found ? w_idx_inc : w_idx_dec;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_grid_solver_core.sv
// Randomised bench for grid_solver_core (ORDER=2) with a scan-based search model.
module tb_grid_solver_core;
   localparam int unsigned ORDER = 2;
   localparam int L     = 4;
   localparam int CELLS = 16;
   localparam int TMAX  = 5;
   localparam int AMAX  = 20000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic       wr_en_a = 1'b0, wr_en_b = 1'b0, start_a = 1'b0, start_b = 1'b0;
   logic [3:0] wr_addr = '0, rd_addr = '0;
   logic [2:0] wr_value = '0;

   grid_solver_core_if #(.ORDER(ORDER)) ba ();
   grid_solver_core_if #(.ORDER(ORDER)) bt ();

   assign ba.wr_en = wr_en_a;  assign ba.start = start_a;
   assign ba.wr_addr = wr_addr; assign ba.wr_value = wr_value; assign ba.rd_addr = rd_addr;
   assign bt.wr_en = wr_en_b;  assign bt.start = start_b;
   assign bt.wr_addr = wr_addr; assign bt.wr_value = wr_value; assign bt.rd_addr = rd_addr;

   grid_solver_core #(.ORDER(ORDER), .MAX_CYCLES(AMAX)) dut_a (.clock(clk), .reset(rst_n), .bus(ba));
   grid_solver_core #(.ORDER(ORDER), .MAX_CYCLES(TMAX)) dut_t (.clock(clk), .reset(rst_n), .bus(bt));

   int total = 0, bad = 0;
   int g_a [CELLS], g_t [CELLS], m_grid [CELLS];
   int m_steps;
   bit m_succ, m_tmo;
   int lit_empty [CELLS] = '{1,2,3,4, 3,4,1,2, 2,1,4,3, 4,3,2,1};

   bit run_active = 0, run_done = 0, sel = 0;
   int k = 0, exp_edge = 0, exp_cnt = 0, done_k = 0;
   bit exp_succ = 0, exp_tmo = 0;
   logic c_busy, c_done, c_succ, c_tmo;
   logic [31:0] c_cnt;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic bit peers(input int a, input int b);
      int ra = a / L, ca = a % L, rb = b / L, cb = b % L;
      return (a != b) && ((ra == rb) || (ca == cb) || ((ra / 2 == rb / 2) && (ca / 2 == cb / 2)));
   endfunction

   function automatic int next_ok(input int idx, input int v);
      for (int u = v + 1; u <= L; u++) begin
         bit ok = 1;
         for (int j = 0; j < CELLS; j++)
            if (peers(idx, j) && m_grid[j] == u) ok = 0;
         if (ok) return u;
      end
      return 0;
   endfunction

   // Reference: restart from givens, reject duplicate givens, then row-major DFS
   task automatic model_run(input bit s);
      int gv [CELLS];
      int idx, maxc, u;
      bit fwd, conflict, fin;
      maxc = s ? TMAX : AMAX;
      for (int i = 0; i < CELLS; i++) begin
         gv[i] = s ? g_t[i] : g_a[i];
         m_grid[i] = gv[i];
      end
      conflict = 0;
      for (int i = 0; i < CELLS; i++)
         for (int j = i + 1; j < CELLS; j++)
            if (gv[i] != 0 && gv[i] == gv[j] && peers(i, j)) conflict = 1;
      m_steps = 0; m_succ = 0; m_tmo = 0;
      fin = conflict;
      idx = 0; fwd = 1;
      while (!fin) begin
         if (idx == CELLS) begin m_succ = 1; fin = 1; end
         else if (idx < 0) fin = 1;
         else if (maxc != 0 && m_steps == maxc) begin m_tmo = 1; fin = 1; end
         else begin
            m_steps++;
            if (gv[idx] != 0) idx = fwd ? idx + 1 : idx - 1;
            else begin
               u = next_ok(idx, m_grid[idx]);
               m_grid[idx] = u;
               fwd = (u != 0);
               idx = fwd ? idx + 1 : idx - 1;
            end
         end
      end
   endtask

   task automatic set_given(input bit s, input int a, input int v);
      if (v <= L) begin
         if (s) g_t[a] = v; else g_a[a] = v;
      end
   endtask

   task automatic wr(input bit s, input int a, input int v);
      @(negedge clk);
      wr_addr = 4'(a); wr_value = 3'(v);
      if (s) wr_en_b = 1; else wr_en_a = 1;
      @(negedge clk);
      wr_en_a = 0; wr_en_b = 0;
      set_given(s, a, v);
   endtask

   // Per-cycle compare of the selected instance against the model's timeline
   initial begin
      forever begin
         @(negedge clk);
         if (run_active) begin
            c_busy = sel ? bt.busy : ba.busy;
            c_done = sel ? bt.done : ba.done;
            c_succ = sel ? bt.success : ba.success;
            c_tmo  = sel ? bt.timeout : ba.timeout;
            c_cnt  = sel ? bt.cycle_count : ba.cycle_count;
            if (k < exp_edge) begin
               chk("running_flags", int'({c_busy, c_done, c_succ, c_tmo}), 8);
            end else begin
               chk("done", int'(c_done), 1);
               chk("busy_at_done", int'(c_busy), 0);
               chk("success", int'(c_succ), int'(exp_succ));
               chk("timeout", int'(c_tmo), int'(exp_tmo));
               chk("cycle_count", int'(c_cnt), exp_cnt);
               done_k = k;
               run_active = 0;
               run_done = 1;
            end
            k++;
         end
      end
   end

   task automatic launch(input bit s, input bit co, input int ca, input int cv);
      if (co) set_given(s, ca, cv);
      model_run(s);
      @(negedge clk); #1;
      wr_addr = 4'(ca); wr_value = 3'(cv);
      if (co) begin if (s) wr_en_b = 1; else wr_en_a = 1; end
      if (s) start_b = 1; else start_a = 1;
      sel = s; k = 0; exp_edge = CELLS + m_steps + 1;
      exp_succ = m_succ; exp_tmo = m_tmo; exp_cnt = m_steps;
      run_done = 0; run_active = 1;
      @(posedge clk); #1;
      start_a = 0; start_b = 0; wr_en_a = 0; wr_en_b = 0;
   endtask

   task automatic run(input bit s, input bit poke, input bit co);
      int ca, cv;
      ca = int'($urandom_range(0, CELLS - 1));
      cv = int'($urandom_range(1, L));
      launch(s, co, ca, cv);
      if (poke) begin
         repeat (3) @(posedge clk);
         #1;
         wr_addr = 4'($urandom_range(0, CELLS - 1)); wr_value = 3'($urandom_range(1, L));
         if (s) begin start_b = 1; wr_en_b = 1; end else begin start_a = 1; wr_en_a = 1; end
         @(posedge clk); #1;
         start_a = 0; start_b = 0; wr_en_a = 0; wr_en_b = 0;
      end
      for (int c = 0; c < 30000 && !run_done; c++) @(negedge clk);
      #1;
      if (!run_done) begin
         chk("run_timeout_bound", 0, 1);
         run_active = 0;
      end
   endtask

   task automatic check_grid(input bit s);
      for (int i = 0; i < CELLS; i++) begin
         rd_addr = 4'(i); #1;
         chk($sformatf("cell%0d", i), int'(s ? bt.rd_value : ba.rd_value), m_grid[i]);
      end
   endtask

   initial begin
      for (int i = 0; i < CELLS; i++) begin g_a[i] = 0; g_t[i] = 0; end
      repeat (3) @(negedge clk);
      chk("rst_flags_a", int'({ba.busy, ba.done, ba.success, ba.timeout}), 0);
      chk("rst_flags_t", int'({bt.busy, bt.done, bt.success, bt.timeout}), 0);
      chk("rst_count", int'(ba.cycle_count), 0);
      for (int i = 0; i < CELLS; i++) begin
         rd_addr = 4'(i); #1;
         chk($sformatf("rst_cell%0d", i), int'(ba.rd_value), 0);
      end
      @(negedge clk); rst_n = 1;

      run(0, 0, 0);
      chk("empty_done_edge", done_k, 33);
      chk("empty_count", int'(ba.cycle_count), 16);
      for (int i = 0; i < CELLS; i++) begin
         rd_addr = 4'(i); #1;
         chk($sformatf("empty_cell%0d", i), int'(ba.rd_value), lit_empty[i]);
      end
      check_grid(0);

      run(1, 0, 0);
      chk("tmo_flag", int'(bt.timeout), 1);
      chk("tmo_success", int'(bt.success), 0);
      chk("tmo_count", int'(bt.cycle_count), 5);
      check_grid(1);

      wr(0, 0, 1); wr(0, 1, 1);
      run(0, 0, 0);
      chk("conf_done_edge", done_k, 17);
      chk("conf_flags", int'({ba.success, ba.timeout}), 0);
      chk("conf_count", int'(ba.cycle_count), 0);
      check_grid(0);

      for (int a = 0; a < CELLS; a++) wr(0, a, 0);
      wr(0, 1, 2); wr(0, 2, 3); wr(0, 3, 1); wr(0, 8, 4); wr(0, 5, 7);
      run(0, 0, 0);
      chk("unsolv_flags", int'({ba.done, ba.success, ba.timeout}), 4);
      check_grid(0);

      for (int it = 0; it < 20; it++) begin
         int n;
         if (it % 5 == 0) for (int a = 0; a < CELLS; a++) wr(0, a, 0);
         n = int'($urandom_range(0, 4));
         repeat (n) wr(0, int'($urandom_range(0, CELLS - 1)), int'($urandom_range(0, 7)));
         run(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         check_grid(0);
      end

      for (int a = 0; a < CELLS; a++) wr(0, a, 0);
      launch(0, 0, 0, 1);
      for (int c = 0; c < 100 && k < 20; c++) @(negedge clk);
      #1;
      run_active = 0;
      rst_n = 0;
      #1;
      chk("abort_flags", int'({ba.busy, ba.done, ba.success, ba.timeout}), 0);
      chk("abort_count", int'(ba.cycle_count), 0);
      rd_addr = 4'd0; #1;
      chk("abort_cell0", int'(ba.rd_value), 0);
      @(negedge clk); rst_n = 1;
      for (int i = 0; i < CELLS; i++) begin g_a[i] = 0; g_t[i] = 0; end
      wr(0, 0, 4);
      run(0, 0, 0);
      rd_addr = 4'd0; #1;
      chk("rerun_cell0", int'(ba.rd_value), 4);
      chk("rerun_success", int'(ba.success), 1);
      check_grid(0);
      run(0, 0, 0);
      check_grid(0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/grid_solver_core.md
Name: grid_solver_core

Overview:
- Parametrised backtracking Sudoku solver for grids of any order.
- Givens are loaded through a write port; `start` launches a mask-building pass, then a depth-first search.
- Completion is reported through level `done`/`success`/`timeout` flags; the solved grid is read back through an addressed read port.
- Replaces the fixed-size grid with a generalised core that adds conflict detection, a cycle budget and restart-from-givens.

Parameters:
ORDER, 2, block side length; side L = ORDER*ORDER, CELLS = L*L
MAX_CYCLES, 20000, SOLVE-state cycle budget; 0 = unlimited
Derived (localparam): VW = $clog2(L+1) value width, AW = $clog2(CELLS) address width, CW = 32 counter width

Ports:
clock  in  1  single clock, all state rises on posedge
reset  in  1  asynchronous, active-low; 0 clears all state immediately
wr_en  in  1  load given, honoured only in IDLE or DONE
wr_addr  in  AW  row-major cell index (row*L+col)
wr_value  in  VW  given value 1..L; 0 clears the given; values >L are ignored
start  in  1  launch solve, honoured only in IDLE or DONE
rd_addr  in  AW  readout cell index
rd_value  out  VW  combinational value of cell rd_addr (0 = empty)
busy  out  1  high in INIT or SOLVE
done  out  1  level, high in DONE until next accepted start or reset
success  out  1  valid while done; 1 = complete legal grid
timeout  out  1  valid while done; 1 = budget exhausted
cycle_count  out  CW  SOLVE cycles consumed by last/current run

Behaviour:
- Reset (reset=0): state IDLE; all cells 0; given flags, masks and index cleared; busy/done/success/timeout 0; cycle_count 0.
- Storage:
  - Per cell: value (VW) and given flag.
  - Per row, column and block: L-bit occupancy mask; bit v-1 set means value v is used.
- IDLE: wr_en writes the value and sets given=(wr_value!=0). start -> INIT, index=0, all masks cleared, done/success/timeout cleared, cycle_count=0.
- INIT (exactly CELLS cycles, one cell per cycle, index 0..CELLS-1):
  - Non-given cells are set to 0.
  - A given value v whose bit is already set in its row, column or block mask raises a conflict flag; otherwise the bit is set.
  - After cell CELLS-1: on conflict -> DONE with success=0, timeout=0. Otherwise -> SOLVE, index=0, dir=forward.
- SOLVE (one step per cycle; cycle_count increments every SOLVE cycle):
  - Given cell: index += 1 if forward, index -= 1 if backward.
  - Non-given cell holding v (0 allowed): candidate = lowest u with v < u <= L and u clear in row|column|block masks. Priority encoder, same cycle.
  - Candidate found: clear the old v's mask bits if v != 0, write u, set u's bits, dir=forward, index += 1.
  - No candidate: clear v's bits if v != 0, write 0, dir=backward, index -= 1.
  - Index reaching CELLS -> DONE, success=1.
  - Backtrack below index 0 -> DONE, success=0.
  - cycle_count == MAX_CYCLES (MAX_CYCLES != 0), checked before the step -> DONE, success=0, timeout=1. Cell contents are left as they were.
  - Index/dir registers are wide enough to represent -1 and CELLS.
- DONE: outputs hold. wr_en permitted. start -> INIT, which restarts from givens only.
- Ignored events: start or wr_en during INIT/SOLVE is ignored, with no side effects. If start and wr_en arrive in the same idle cycle, the write takes effect first and INIT sees it.
- reset mid-run aborts immediately; givens are lost.
- Latency: for an instance whose empty-grid search never backtracks, done rises on edge 2*CELLS+1 after the edge that samples start (CELLS INIT + CELLS SOLVE + 1 transition).

Test Plan:
- Reset: hold reset=0 with clock running -> busy=done=success=timeout=0; rd_value=0 for all 16 addrs (ORDER=2).
- Empty 4x4 start -> done at edge 33, success=1, cycle_count=16; rows read 1234 / 3412 / 2143 / 4321.
- Conflicting givens: addr0=1, addr1=1, start -> done after INIT (edge 17), success=0, timeout=0, cycle_count=0.
- Unsolvable non-conflicting givens: addr1=2, addr2=3, addr3=1, addr8=4 -> done, success=0, timeout=0; all non-given cells read 0.
- Timeout: MAX_CYCLES=5 instance, empty grid -> done, timeout=1, success=0, cycle_count=5.
- Reset mid-SOLVE, then reload addr0=4 and start -> clean rerun, success=1, rd_value(0)=4; start again from DONE reproduces an identical grid.
